// File: rtl/ahb_txn_arbiter_if.sv
// Bundle of requester-side, master-side and status signals of ahb_txn_arbiter.
// Modport 'slave' is the arbiter's view.
// Modport 'master' is the view of the surrounding logic: the requesters and the AHB-Lite master port.
interface ahb_txn_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  // Requester side
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ-1:0]            i_req_rd0_wr1;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wr_data;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [NUM_REQ-1:0]            o_req_rd_valid;
  logic [DATA_WIDTH-1:0]         o_req_rd_data;
  logic [ID_W-1:0]               o_grant_id;

  // AHB-Lite master transaction port
  logic                          o_m_valid;
  logic                          o_m_rd0_wr1;
  logic [ADDR_WIDTH-1:0]         o_m_addr;
  logic [DATA_WIDTH-1:0]         o_m_wr_data;
  logic                          i_m_ready;
  logic                          i_m_rd_valid;
  logic [DATA_WIDTH-1:0]         i_m_rd_data;

  // Status
  logic                          o_rsp_err;

  modport slave (
    input  i_req_valid, i_req_rd0_wr1, i_req_addr, i_req_wr_data,
    input  i_m_ready, i_m_rd_valid, i_m_rd_data,
    output o_req_ready, o_req_rd_valid, o_req_rd_data, o_grant_id,
    output o_m_valid, o_m_rd0_wr1, o_m_addr, o_m_wr_data, o_rsp_err
  );

  modport master (
    output i_req_valid, i_req_rd0_wr1, i_req_addr, i_req_wr_data,
    output i_m_ready, i_m_rd_valid, i_m_rd_data,
    input  o_req_ready, o_req_rd_valid, o_req_rd_data, o_grant_id,
    input  o_m_valid, o_m_rd0_wr1, o_m_addr, o_m_wr_data, o_rsp_err
  );
endinterface

// File: rtl/ahb_txn_arbiter.sv
// Shares one AHB-Lite master transaction port among NUM_REQ requesters.
//
// A grant is held until the master accepts it. Read responses are routed back
// to the issuing requester through an in-order tag FIFO.
//
// Arbitration policy:
//   - Macro AHB_ARB_RR_EN defined: round-robin.
//   - Macro undefined: fixed priority, requester 0 highest.
module ahb_txn_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 2
) (
  input  logic             i_clk_ahb,
  input  logic             i_rstn_ahb,
  ahb_txn_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_OPEN, ST_HELD} arb_state_e;

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     held_id_q, held_id_d;
  logic [ID_W-1:0]     last_grant_q;
  logic [ID_W-1:0]     pick;
  logic [ID_W-1:0]     winner;
  logic                m_valid;
  logic                accept;
  logic [NUM_REQ-1:0]  eligible;

  logic [ID_W-1:0]     tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                tag_full, tag_empty;
  logic                push, pop;
  logic                rsp_err_q;

  assign tag_full  = (count_q == CNT_W'(TAG_DEPTH));
  assign tag_empty = (count_q == '0);

  // Reads need a free tag slot; writes never wait on the FIFO.
  assign eligible = bus.i_req_valid & (bus.i_req_rd0_wr1 | {NUM_REQ{~tag_full}});

`ifdef AHB_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr_q;

  // Round-robin pick: first eligible requester after the last accepted one.
  always_comb begin
    logic [ID_W-1:0] idx;
    logic            found;
    // NOTE: every comb output gets a default before any branch, so no latch is inferred.
    pick  = '0;
    found = 1'b0;
    idx   = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
      if (!found && eligible[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Pointer advances only on an accepted transfer.
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb)  rr_ptr_q <= ID_W'(NUM_REQ - 1);
    else if (accept)  rr_ptr_q <= winner;
  end
`else
  // Fixed priority pick: lowest-numbered eligible requester.
  always_comb begin
    logic found;
    // NOTE: every comb output gets a default before any branch, so no latch is inferred.
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && eligible[i]) begin
        pick  = ID_W'(i);
        found = 1'b1;
      end
    end
  end
`endif

  // Arbitration state register and held requester id.
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      state_q   <= ST_OPEN;
      held_id_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q   <= state_d;
      held_id_q <= held_id_d;
    end
  end

  // Next state: hold a stalled grant; release it on accept or if the requester drops valid.
  always_comb begin
    state_d   = state_q;
    held_id_d = held_id_q;
    case (state_q)
      ST_OPEN: begin
        if (m_valid && !bus.i_m_ready) begin
          state_d   = ST_HELD;
          held_id_d = winner;
        end
      end
      ST_HELD: begin
        if (accept || !bus.i_req_valid[held_id_q]) state_d = ST_OPEN;
      end
      default: state_d = ST_OPEN;
    endcase
  end

  // Outputs: winner selection, master payload mux, ready strobe and grant id.
  always_comb begin
    winner  = (state_q == ST_HELD) ? held_id_q : pick;
    m_valid = (state_q == ST_HELD) ? eligible[held_id_q] : |eligible;
    accept  = m_valid & bus.i_m_ready;

    bus.o_m_valid   = m_valid;
    bus.o_m_rd0_wr1 = m_valid & bus.i_req_rd0_wr1[winner];
    bus.o_m_addr    = m_valid ? bus.i_req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    bus.o_m_wr_data = m_valid ? bus.i_req_wr_data[winner*DATA_WIDTH +: DATA_WIDTH] : '0;

    bus.o_req_ready = '0;
    if (accept) bus.o_req_ready[winner] = 1'b1;

    bus.o_grant_id  = m_valid ? winner : last_grant_q;
  end

  // Remember the last winner so the grant id holds while idle.
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb)   last_grant_q <= '0;
    else if (m_valid)  last_grant_q <= winner;
  end

  assign push = accept & ~bus.i_req_rd0_wr1[winner];
  assign pop  = bus.i_m_rd_valid & ~tag_empty;

  // Response routing: the FIFO head names the requester that owns the returning read.
  always_comb begin
    bus.o_req_rd_valid = '0;
    if (pop) bus.o_req_rd_valid[tag_mem[rd_ptr_q]] = 1'b1;
    bus.o_req_rd_data  = bus.i_m_rd_valid ? bus.i_m_rd_data : '0;
  end

  // Tag storage: an entry is only read after it has been written.
  // NOTE: storage arrays are not reset; the pointers and count alone define validity.
  always_ff @(posedge i_clk_ahb) begin
    if (push) tag_mem[wr_ptr_q] <= winner;
  end

  // FIFO pointers, occupancy and sticky orphan-response flag.
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (bus.i_m_rd_valid && tag_empty) rsp_err_q <= 1'b1;
    end
  end

  assign bus.o_rsp_err = rsp_err_q;

endmodule

// File: tb/tb_ahb_txn_arbiter.sv
// Testbench for ahb_txn_arbiter with NUM_REQ=2 and TAG_DEPTH=2.
// It checks the default fixed-priority build.
// Rows that differ under AHB_ARB_RR_EN carry round-robin expectations.
module tb_ahb_txn_arbiter;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TD = 2;
  localparam logic [31:0] WD0 = 32'hD0D0_0000;
  localparam logic [31:0] WD1 = 32'hD1D1_1111;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  ahb_txn_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ahb_txn_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)
  ) dut (
    .i_clk_ahb (clk),
    .i_rstn_ahb(rstn),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  valid;
    logic [1:0]  wr;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        m_ready;
    logic        m_rdv;
    logic [31:0] m_rdata;
    logic [1:0]  e_ready;
    logic        e_mvalid;
    logic        e_mwr;
    logic        e_gid;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [1:0]  e_rdv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input string n, input logic [1:0] v, input logic [1:0] wr,
    input logic [31:0] a0, input logic [31:0] a1,
    input logic mr, input logic rdv, input logic [31:0] rd,
    input logic [1:0] er, input logic emv, input logic emw, input logic egid,
    input logic [31:0] ea, input logic [31:0] ewd,
    input logic [1:0] erv, input logic [31:0] erd);
    vec_t r;
    r.name = n;       r.valid = v;     r.wr = wr;       r.a0 = a0;     r.a1 = a1;
    r.m_ready = mr;   r.m_rdv = rdv;   r.m_rdata = rd;
    r.e_ready = er;   r.e_mvalid = emv; r.e_mwr = emw;  r.e_gid = egid;
    r.e_addr = ea;    r.e_wdata = ewd; r.e_rdv = erv;   r.e_rdata = erd;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.i_req_valid   = v.valid;
    bus.i_req_rd0_wr1 = v.wr;
    bus.i_req_addr    = {v.a1, v.a0};
    bus.i_req_wr_data = {WD1, WD0};
    bus.i_m_ready     = v.m_ready;
    bus.i_m_rd_valid  = v.m_rdv;
    bus.i_m_rd_data   = v.m_rdata;
  endtask

  task automatic check_row(input vec_t v);
    check({v.name, ".req_ready"},   64'(bus.o_req_ready),    64'(v.e_ready));
    check({v.name, ".m_valid"},     64'(bus.o_m_valid),      64'(v.e_mvalid));
    check({v.name, ".m_rd0_wr1"},   64'(bus.o_m_rd0_wr1),    64'(v.e_mwr));
    check({v.name, ".grant_id"},    64'(bus.o_grant_id),     64'(v.e_gid));
    check({v.name, ".m_addr"},      64'(bus.o_m_addr),       64'(v.e_addr));
    check({v.name, ".m_wr_data"},   64'(bus.o_m_wr_data),    64'(v.e_wdata));
    check({v.name, ".req_rd_valid"},64'(bus.o_req_rd_valid), 64'(v.e_rdv));
    check({v.name, ".req_rd_data"}, 64'(bus.o_req_rd_data),  64'(v.e_rdata));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".m_valid"},      64'(bus.o_m_valid),      64'd0);
    check({tag, ".req_ready"},    64'(bus.o_req_ready),    64'd0);
    check({tag, ".req_rd_valid"}, 64'(bus.o_req_rd_valid), 64'd0);
    check({tag, ".req_rd_data"},  64'(bus.o_req_rd_data),  64'd0);
    check({tag, ".m_addr"},       64'(bus.o_m_addr),       64'd0);
    check({tag, ".m_wr_data"},    64'(bus.o_m_wr_data),    64'd0);
    check({tag, ".m_rd0_wr1"},    64'(bus.o_m_rd0_wr1),    64'd0);
    check({tag, ".grant_id"},     64'(bus.o_grant_id),     64'd0);
  endtask

  task automatic idle_inputs();
    bus.i_req_valid   = '0;
    bus.i_req_rd0_wr1 = '0;
    bus.i_req_addr    = '0;
    bus.i_req_wr_data = '0;
    bus.i_m_ready     = 1'b0;
    bus.i_m_rd_valid  = 1'b0;
    bus.i_m_rd_data   = '0;
  endtask

  initial begin
    // ---------------- vector table ----------------
    // Both requesters write continuously with the master always ready.
`ifdef AHB_ARB_RR_EN
    vecs.push_back(mk("wr_both_a", 2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 0, 2'b01, 1, 1, 0, 32'h10, WD0, 2'b00, 0));
    vecs.push_back(mk("wr_both_b", 2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 0, 2'b10, 1, 1, 1, 32'h20, WD1, 2'b00, 0));
    vecs.push_back(mk("wr_both_c", 2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 0, 2'b01, 1, 1, 0, 32'h10, WD0, 2'b00, 0));
    vecs.push_back(mk("wr_both_d", 2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 0, 2'b10, 1, 1, 1, 32'h20, WD1, 2'b00, 0));
    vecs.push_back(mk("idle_hold", 2'b00, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0));
`else
    vecs.push_back(mk("wr_both_a", 2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 0, 2'b01, 1, 1, 0, 32'h10, WD0, 2'b00, 0));
    vecs.push_back(mk("wr_both_b", 2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 0, 2'b01, 1, 1, 0, 32'h10, WD0, 2'b00, 0));
    vecs.push_back(mk("wr_both_c", 2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 0, 2'b01, 1, 1, 0, 32'h10, WD0, 2'b00, 0));
    vecs.push_back(mk("wr_both_d", 2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 0, 2'b01, 1, 1, 0, 32'h10, WD0, 2'b00, 0));
    vecs.push_back(mk("idle_hold", 2'b00, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0));
`endif
    // Requester 1 read at 0x100 stalls 3 cycles; requester 0 joins in cycle 2.
    vecs.push_back(mk("hold_c1",  2'b10, 2'b00, 32'h40, 32'h100, 0, 0, 0, 2'b00, 1, 0, 1, 32'h100, WD1, 2'b00, 0));
    vecs.push_back(mk("hold_c2",  2'b11, 2'b01, 32'h40, 32'h100, 0, 0, 0, 2'b00, 1, 0, 1, 32'h100, WD1, 2'b00, 0));
    vecs.push_back(mk("hold_c3",  2'b11, 2'b01, 32'h40, 32'h100, 0, 0, 0, 2'b00, 1, 0, 1, 32'h100, WD1, 2'b00, 0));
    vecs.push_back(mk("hold_acc", 2'b11, 2'b01, 32'h40, 32'h100, 1, 0, 0, 2'b10, 1, 0, 1, 32'h100, WD1, 2'b00, 0));
    vecs.push_back(mk("after_hold", 2'b01, 2'b01, 32'h40, 0, 1, 0, 0, 2'b01, 1, 1, 0, 32'h40, WD0, 2'b00, 0));
    vecs.push_back(mk("rsp_hold", 2'b00, 2'b00, 0, 0, 1, 1, 32'h1234, 2'b00, 0, 0, 0, 0, 0, 2'b10, 32'h1234));
    // Back-to-back reads; responses come back in order.
    vecs.push_back(mk("rd_0",   2'b01, 2'b00, 32'h200, 0, 1, 0, 0, 2'b01, 1, 0, 0, 32'h200, WD0, 2'b00, 0));
    vecs.push_back(mk("rd_1",   2'b10, 2'b00, 0, 32'h300, 1, 0, 0, 2'b10, 1, 0, 1, 32'h300, WD1, 2'b00, 0));
    vecs.push_back(mk("rsp_0",  2'b00, 2'b00, 0, 0, 1, 1, 32'hAAAA0000, 2'b00, 0, 0, 1, 0, 0, 2'b01, 32'hAAAA0000));
    vecs.push_back(mk("rsp_1",  2'b00, 2'b00, 0, 0, 1, 1, 32'hBBBB1111, 2'b00, 0, 0, 1, 0, 0, 2'b10, 32'hBBBB1111));
    // Fill the tag FIFO. A read then waits, while a write still passes.
    vecs.push_back(mk("fill_0",  2'b01, 2'b00, 32'h500, 0, 1, 0, 0, 2'b01, 1, 0, 0, 32'h500, WD0, 2'b00, 0));
    vecs.push_back(mk("fill_1",  2'b10, 2'b00, 0, 32'h600, 1, 0, 0, 2'b10, 1, 0, 1, 32'h600, WD1, 2'b00, 0));
    vecs.push_back(mk("full_wr", 2'b11, 2'b10, 32'h500, 32'h700, 1, 0, 0, 2'b10, 1, 1, 1, 32'h700, WD1, 2'b00, 0));
    vecs.push_back(mk("full_blk",2'b01, 2'b00, 32'h500, 0, 1, 0, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0));
    vecs.push_back(mk("full_pop",2'b01, 2'b00, 32'h500, 0, 1, 1, 32'h5555, 2'b00, 0, 0, 1, 0, 0, 2'b01, 32'h5555));
    vecs.push_back(mk("unblk",   2'b01, 2'b00, 32'h500, 0, 1, 0, 0, 2'b01, 1, 0, 0, 32'h500, WD0, 2'b00, 0));
    vecs.push_back(mk("drain_1", 2'b00, 2'b00, 0, 0, 1, 1, 32'h6666, 2'b00, 0, 0, 0, 0, 0, 2'b10, 32'h6666));
    vecs.push_back(mk("drain_0", 2'b00, 2'b00, 0, 0, 1, 1, 32'h7777, 2'b00, 0, 0, 0, 0, 0, 2'b01, 32'h7777));
    // The held requester drops valid: the grant is released with no transfer.
    vecs.push_back(mk("drop_c1", 2'b10, 2'b00, 0, 32'h800, 0, 0, 0, 2'b00, 1, 0, 1, 32'h800, WD1, 2'b00, 0));
    vecs.push_back(mk("drop_c2", 2'b01, 2'b01, 32'h900, 0, 1, 0, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0));
    vecs.push_back(mk("drop_c3", 2'b01, 2'b01, 32'h900, 0, 1, 0, 0, 2'b01, 1, 1, 0, 32'h900, WD0, 2'b00, 0));
    vecs.push_back(mk("idle_end",2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0));

    // ---------------- reset ----------------
    idle_inputs();
    rstn = 1'b0;
    #1;
    check_reset_outputs("reset");
    check("reset.rsp_err", 64'(bus.o_rsp_err), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_row(vecs[i]);
    end

    // ---------------- orphan response: sticky error ----------------
    @(negedge clk);
    idle_inputs();
    bus.i_m_rd_valid = 1'b1;
    bus.i_m_rd_data  = 32'h9999;
    #1;
    check("orphan.req_rd_valid", 64'(bus.o_req_rd_valid), 64'd0);
    check("orphan.rsp_err_pre",  64'(bus.o_rsp_err),      64'd0);
    @(negedge clk);
    bus.i_m_rd_valid = 1'b0;
    #1;
    check("orphan.rsp_err_set",  64'(bus.o_rsp_err),      64'd1);
    repeat (3) @(negedge clk);
    #1;
    check("orphan.rsp_err_sticky", 64'(bus.o_rsp_err),    64'd1);

    // ---------------- reset with a read outstanding ----------------
    @(negedge clk);
    bus.i_req_valid   = 2'b01;
    bus.i_req_rd0_wr1 = 2'b00;
    bus.i_req_addr    = {32'h0, 32'hA00};
    bus.i_m_ready     = 1'b1;
    #1;
    check("rst_mid.accept", 64'(bus.o_req_ready), 64'd1);
    @(negedge clk);
    idle_inputs();
    rstn = 1'b0;
    #1;
    check_reset_outputs("rst_mid.in_reset");
    check("rst_mid.rsp_err_cleared", 64'(bus.o_rsp_err), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    bus.i_m_rd_valid = 1'b1;
    bus.i_m_rd_data  = 32'hCAFE;
    #1;
    check("rst_mid.spurious_rd_valid", 64'(bus.o_req_rd_valid), 64'd0);
    @(negedge clk);
    bus.i_m_rd_valid = 1'b0;
    #1;
    check_reset_outputs("rst_mid.after");
    check("rst_mid.rsp_err", 64'(bus.o_rsp_err), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
